// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   AW_DEF / DW_DEF : default register address and data widths
//   REG_ZERO        : architectural zero register, never written
//   ALU / MDU / LSU : requester index assignment on the writeback port
package rf_wb_arbiter_pkg;

    localparam int unsigned AW_DEF   = 5;
    localparam int unsigned DW_DEF   = 32;
    localparam int unsigned REG_ZERO = 0;

    localparam int unsigned ALU = 0;
    localparam int unsigned MDU = 1;
    localparam int unsigned LSU = 2;

endpackage

// File: rtl/rf_wb_arbiter_rr_pick.sv
// Combinational round-robin picker. Scans last+1, last+2, ... (mod N) and
// grants the first set bit of req.
//   req  : request mask
//   last : index granted most recently (highest priority goes to last+1)
//   gnt  : one-hot grant, zero when req is zero
//   idx  : index of the granted bit (0 when nothing granted)
//   any  : a grant was issued
module rf_wb_arbiter_rr_pick
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        logic [IW-1:0] pos;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            pos = IW'((32'(last) + k) % N);
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter. NREQ requesters share the single write
// port through a round-robin valid/ready handshake; the winner is registered
// into one writeback stage that drives the register file and doubles as the
// pending-write tag for forwarding.
//   clk, clrn          : clock, asynchronous active-low reset
//   hold, flush        : synchronous stall / kill; both block new grants
//   req_valid/wn/d     : per-requester write requests (packed, i at [i*W +: W])
//   req_ready          : combinational one-hot grant
//   we, wn, d          : registered register-file write port
//   wb_src             : requester owning the current writeback stage
//   grant_cnt          : accepted handshakes, wrapping 16-bit count
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              hold,
    input  logic              flush,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_wn,
    input  logic [NREQ*DW-1:0] req_d,
    output logic [NREQ-1:0]   req_ready,
    output logic              we,
    output logic [AW-1:0]     wn,
    output logic [DW-1:0]     d,
    output logic [IW-1:0]     wb_src,
    output logic [15:0]       grant_cnt
);

    logic [IW-1:0]   last_q;
    logic            we_q;
    logic [AW-1:0]   wn_q;
    logic [DW-1:0]   d_q;
    logic [IW-1:0]   src_q;
    logic [15:0]     cnt_q;

    logic [NREQ-1:0] req_mask;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [AW-1:0]   sel_wn;
    logic [DW-1:0]   sel_d;

    // flush and hold only gate new grants; an already loaded stage still retires
    assign req_mask = (hold || flush) ? '0 : req_valid;

    rf_wb_arbiter_rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr_pick (
        .req  (req_mask),
        .last (last_q),
        .gnt  (gnt),
        .idx  (gnt_idx),
        .any  (gnt_any)
    );

    // One-hot AND-OR mux of the winning request
    always_comb begin
        sel_wn = '0;
        sel_d  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_wn = sel_wn | req_wn[i*AW +: AW];
                sel_d  = sel_d  | req_d[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            last_q <= IW'(NREQ - 1);
            we_q   <= 1'b0;
            wn_q   <= '0;
            d_q    <= '0;
            src_q  <= '0;
            cnt_q  <= '0;
        end else begin
            // writes to r0 are accepted but suppressed at the port
            we_q <= gnt_any && (sel_wn != AW'(REG_ZERO));
            if (gnt_any) begin
                wn_q   <= sel_wn;
                d_q    <= sel_d;
                src_q  <= gnt_idx;
                last_q <= gnt_idx;
                cnt_q  <= cnt_q + 16'd1;
            end
        end
    end

    assign req_ready = gnt;
    assign we        = we_q;
    assign wn        = wn_q;
    assign d         = d_q;
    assign wb_src    = src_q;
    assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (NREQ=3, AW=5, DW=32).
module tb_rf_wb_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned IW   = 2;

    logic              clk;
    logic              clrn;
    logic              hold;
    logic              flush;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_wn;
    logic [NREQ*DW-1:0] req_d;
    logic [NREQ-1:0]   req_ready;
    logic              we;
    logic [AW-1:0]     wn;
    logic [DW-1:0]     d;
    logic [IW-1:0]     wb_src;
    logic [15:0]       grant_cnt;

    int n_checks = 0;
    int n_errors = 0;

    rf_wb_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW),
        .IW   (IW)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .hold      (hold),
        .flush     (flush),
        .req_valid (req_valid),
        .req_wn    (req_wn),
        .req_d     (req_d),
        .req_ready (req_ready),
        .we        (we),
        .wn        (wn),
        .d         (d),
        .wb_src    (wb_src),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] w,
                           input logic [DW-1:0] data);
        req_valid[i]         = v;
        req_wn[i*AW +: AW]   = w;
        req_d[i*DW +: DW]    = data;
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb(input string tag, input logic exp_we, input logic [AW-1:0] exp_wn,
                            input logic [DW-1:0] exp_d, input logic [IW-1:0] exp_src);
        check_eq({tag, ".we"}, 32'(we), 32'(exp_we));
        check_eq({tag, ".wn"}, 32'(wn), 32'(exp_wn));
        check_eq({tag, ".d"}, d, exp_d);
        check_eq({tag, ".src"}, 32'(wb_src), 32'(exp_src));
    endtask

    initial begin
        int e;
        clrn      = 1'b0;
        hold      = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_wn    = '0;
        req_d     = '0;

        // Reset with all requesters valid
        set_req(0, 1'b1, 5'd3, 32'h1111_1111);
        set_req(1, 1'b1, 5'd2, 32'h0000_00A1);
        set_req(2, 1'b1, 5'd3, 32'h0000_00A2);
        #12;
        check_wb("reset", 1'b0, 5'd0, 32'h0, 2'd0);
        check_eq("reset.cnt", 32'(grant_cnt), 32'd0);

        tick();
        clrn = 1'b1;
        #1;
        check_eq("first.ready", 32'(req_ready), 32'b001);
        tick();
        check_wb("first", 1'b1, 5'd3, 32'h1111_1111, 2'd0);
        check_eq("first.cnt", 32'(grant_cnt), 32'd1);

        // All valid, continuous round-robin: 1,2,0,1,2,0
        set_req(0, 1'b1, 5'd1, 32'h0000_00A0);
        set_req(2, 1'b1, 5'd3, 32'h0000_00A2);
        for (int c = 0; c < 6; c++) begin
            e = (1 + c) % 3;
            #1;
            check_eq("rr.ready", 32'(req_ready), 32'(1 << e));
            tick();
            check_wb("rr", 1'b1, 5'(e + 1), 32'h0000_00A0 + 32'(e), 2'(e));
        end
        check_eq("rr.cnt", 32'(grant_cnt), 32'd7);

        // r0 write from req1: accepted, not written
        req_valid = '0;
        set_req(1, 1'b1, 5'd0, 32'hDEAD_BEEF);
        #1;
        check_eq("r0.ready", 32'(req_ready), 32'b010);
        tick();
        check_eq("r0.we", 32'(we), 32'd0);
        check_eq("r0.src", 32'(wb_src), 32'd1);
        check_eq("r0.cnt", 32'(grant_cnt), 32'd8);
        // pointer now at 1: with all valid, req2 wins
        req_valid = 3'b111;
        #1;
        check_eq("r0.ptr", 32'(req_ready), 32'b100);
        tick();
        check_wb("r0.next", 1'b1, 5'd3, 32'h0000_00A2, 2'd2);
        check_eq("r0.next.cnt", 32'(grant_cnt), 32'd9);

        // Hold for 3 cycles with req0 valid
        req_valid = 3'b001;
        hold      = 1'b1;
        #1;
        check_eq("hold.we0", 32'(we), 32'd1);
        for (int c = 0; c < 3; c++) begin
            check_eq("hold.ready", 32'(req_ready), 32'd0);
            tick();
            check_eq("hold.we", 32'(we), 32'd0);
        end
        check_eq("hold.cnt", 32'(grant_cnt), 32'd9);
        hold = 1'b0;
        #1;
        check_eq("unhold.ready", 32'(req_ready), 32'b001);
        tick();
        check_wb("unhold", 1'b1, 5'd1, 32'h0000_00A0, 2'd0);

        // Grant req1 in t, flush in t+1 with req2 valid
        req_valid = 3'b010;
        set_req(1, 1'b1, 5'd2, 32'h0000_00B1);
        #1;
        check_eq("fl.t.ready", 32'(req_ready), 32'b010);
        tick();
        req_valid = 3'b100;
        flush     = 1'b1;
        #1;
        check_eq("fl.t1.ready", 32'(req_ready), 32'd0);
        check_wb("fl.t1", 1'b1, 5'd2, 32'h0000_00B1, 2'd1);
        tick();
        flush = 1'b0;
        #1;
        check_eq("fl.t2.we", 32'(we), 32'd0);
        check_eq("fl.t2.ready", 32'(req_ready), 32'b100);
        tick();
        check_wb("fl.t3", 1'b1, 5'd3, 32'h0000_00A2, 2'd2);
        check_eq("fl.cnt", 32'(grant_cnt), 32'd12);

        // Same destination from req0 and req1: req0 first, req1 wins last
        set_req(0, 1'b1, 5'd5, 32'h0000_0055);
        set_req(1, 1'b1, 5'd5, 32'h0000_0066);
        req_valid = 3'b011;
        #1;
        check_eq("same.a.ready", 32'(req_ready), 32'b001);
        tick();
        check_wb("same.a", 1'b1, 5'd5, 32'h0000_0055, 2'd0);
        req_valid = 3'b010;
        #1;
        check_eq("same.b.ready", 32'(req_ready), 32'b010);
        tick();
        check_wb("same.b", 1'b1, 5'd5, 32'h0000_0066, 2'd1);
        check_eq("same.cnt", 32'(grant_cnt), 32'd14);

        // Asynchronous reset while a write is in flight
        req_valid = '0;
        #1;
        clrn = 1'b0;
        #1;
        check_wb("arst", 1'b0, 5'd0, 32'h0, 2'd0);
        check_eq("arst.cnt", 32'(grant_cnt), 32'd0);
        req_valid = 3'b111;
        clrn      = 1'b1;
        #1;
        check_eq("arst.ready", 32'(req_ready), 32'b001);
        tick();
        check_wb("arst.post", 1'b1, 5'd5, 32'h0000_0055, 2'd0);
        check_eq("arst.post.cnt", 32'(grant_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
